// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory port between the fetch stage
// (read-only) and the program loader (read/write). One access is in flight at
// a time. Conflicts are resolved round-robin. A fetch response is dropped when
// a misprediction flush arrives while that fetch is outstanding.
//
// Handshakes:
//   fetch  - f_req is held until f_hit or f_flush; f_hit pulses for one cycle
//            with f_rdata valid.
//   loader - l_req is held until l_done; l_done pulses for one cycle, and
//            l_rdata is valid with it for reads.
//   memory - m_ren/m_wen, m_addr and m_wdata stay stable until m_ready; the
//            access completes in the cycle m_ready is high, with m_rdata valid.
//
// Optional build macro IMEM_ARB_PERF_EN adds the f_wait_cnt and f_drop_cnt
// performance counters.
module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_hit,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_wen,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_ren,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              busy,
    output logic              owner,
`ifdef IMEM_ARB_PERF_EN
    output logic [31:0]       f_wait_cnt,
    output logic [31:0]       f_drop_cnt,
`endif
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = fetch, 1 = loader
    logic              drop_q, drop_d;     // discard the pending fetch response
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
    logic              fetch_ok;
    logic              grant_f;
    logic              grant_l;

    // State and transaction registers; reset abandons any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;
            drop_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            f_rdata_q <= f_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // Next-state: grant in IDLE, wait for m_ready in BUSY, one response cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drop_d    = drop_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        f_rdata_d = f_rdata_q;
        l_rdata_d = l_rdata_q;
        fetch_ok  = 1'b0;
        grant_f   = 1'b0;
        grant_l   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drop_d   = 1'b0;
                // A flushing fetch is asking for a PC that is already stale.
                fetch_ok = f_req && !f_flush;
                if (fetch_ok && l_req) begin
                    // Round-robin: the requester that did not win last time.
                    grant_f = owner_q;
                    grant_l = !owner_q;
                end else begin
                    grant_f = fetch_ok;
                    grant_l = l_req && !fetch_ok;
                end

                if (grant_f) begin
                    addr_d  = f_addr;
                    wdata_d = '0;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    owner_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (grant_l) begin
                    addr_d  = l_addr;
                    wdata_d = l_wdata;
                    ren_d   = !l_wen;
                    wen_d   = l_wen;
                    owner_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (f_flush && !owner_q) begin
                    drop_d = 1'b1;
                end
                if (m_ready) begin
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                    if (owner_q) begin
                        l_rdata_d = m_rdata;
                    end else begin
                        f_rdata_d = m_rdata;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                // No grant here: fetch gets a cycle to advance its PC.
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A flush in the response cycle itself also suppresses the hit.
    assign f_hit       = (state_q == ST_RESP) && !owner_q && !drop_q && !f_flush;
    assign l_done      = (state_q == ST_RESP) && owner_q;
    assign f_rdata     = f_rdata_q;
    assign l_rdata     = l_rdata_q;
    assign m_ren       = ren_q;
    assign m_wen       = wen_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;
    assign dbg_state_o = state_q;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] wait_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        fetch_in_busy;
    logic        drop_evt;

    assign fetch_in_busy = (state_q == ST_BUSY) && !owner_q;
    assign drop_evt      = (state_q == ST_RESP) && !owner_q && (drop_q || f_flush);

    // Saturating counters: fetch stall cycles and discarded fetch responses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (f_req && !f_flush && !fetch_in_busy && !f_hit && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
            if (drop_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign f_wait_cnt = wait_cnt_q;
    assign f_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a table of per-cycle vectors with
// hand-computed outputs, followed by a hand-written reset-mid-access sequence.
module tb_imem_arbiter;

    logic        CLK;
    logic        RST;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_flush;
    logic        f_hit;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_wen;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_done;
    logic [31:0] l_rdata;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        busy;
    logic        owner;
    logic [1:0]  dbg_state;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] f_wait_cnt;
    logic [31:0] f_drop_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_flush    (f_flush),
        .f_hit      (f_hit),
        .f_rdata    (f_rdata),
        .l_req      (l_req),
        .l_wen      (l_wen),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_done     (l_done),
        .l_rdata    (l_rdata),
        .m_ren      (m_ren),
        .m_wen      (m_wen),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready),
        .busy       (busy),
        .owner      (owner),
`ifdef IMEM_ARB_PERF_EN
        .f_wait_cnt (f_wait_cnt),
        .f_drop_cnt (f_drop_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        f_req;
        logic [31:0] f_addr;
        logic        f_flush;
        logic        l_req;
        logic        l_wen;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        e_hit;
        logic        e_done;
        logic        e_ren;
        logic        e_wen;
        logic        e_busy;
        logic        e_owner;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string tag,
                       input logic fr, input logic [31:0] fa, input logic ff,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic mr, input logic [31:0] md,
                       input logic eh, input logic ed, input logic ern, input logic ewn,
                       input logic eb, input logic eo,
                       input logic [31:0] ema, input logic [31:0] emd, input logic [31:0] erd);
        vec_t v;
        v.tag = tag;   v.f_req = fr;  v.f_addr = fa;  v.f_flush = ff;
        v.l_req = lr;  v.l_wen = lw;  v.l_addr = la;  v.l_wdata = ld;
        v.m_ready = mr; v.m_rdata = md;
        v.e_hit = eh;  v.e_done = ed; v.e_ren = ern;  v.e_wen = ewn;
        v.e_busy = eb; v.e_owner = eo;
        v.e_maddr = ema; v.e_mwdata = emd; v.e_rdata = erd;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        f_req   = v.f_req;
        f_addr  = v.f_addr;
        f_flush = v.f_flush;
        l_req   = v.l_req;
        l_wen   = v.l_wen;
        l_addr  = v.l_addr;
        l_wdata = v.l_wdata;
        m_ready = v.m_ready;
        m_rdata = v.m_rdata;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic ok;
        n_vec++;
        ok = (f_hit === v.e_hit) && (l_done === v.e_done) && (m_ren === v.e_ren) &&
             (m_wen === v.e_wen) && (busy === v.e_busy) && (owner === v.e_owner);
        if (v.e_ren || v.e_wen) ok = ok && (m_addr === v.e_maddr);
        if (v.e_wen)            ok = ok && (m_wdata === v.e_mwdata);
        if (v.e_hit)            ok = ok && (f_rdata === v.e_rdata);
        if (v.e_done && !v.l_wen) ok = ok && (l_rdata === v.e_rdata);
        if (!ok) begin
            n_bad++;
            $display("FAIL vec %0d %s: got hit=%b done=%b ren=%b wen=%b busy=%b owner=%b maddr=%h mwdata=%h frd=%h lrd=%h; want hit=%b done=%b ren=%b wen=%b busy=%b owner=%b maddr=%h mwdata=%h rdata=%h",
                     idx, v.tag, f_hit, l_done, m_ren, m_wen, busy, owner, m_addr, m_wdata, f_rdata, l_rdata,
                     v.e_hit, v.e_done, v.e_ren, v.e_wen, v.e_busy, v.e_owner, v.e_maddr, v.e_mwdata, v.e_rdata);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
        l_req = 1'b0; l_wen = 1'b0; l_addr = '0; l_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_m_ren",   {31'd0, m_ren},  32'd0);
        check("rst_m_wen",   {31'd0, m_wen},  32'd0);
        check("rst_f_hit",   {31'd0, f_hit},  32'd0);
        check("rst_l_done",  {31'd0, l_done}, 32'd0);
        check("rst_busy",    {31'd0, busy},   32'd0);
        check("rst_owner",   {31'd0, owner},  32'd1);
        check("rst_m_addr",  m_addr,          32'd0);
        check("rst_f_rdata", f_rdata,         32'd0);
`ifdef IMEM_ARB_PERF_EN
        check("rst_drop_cnt", f_drop_cnt, 32'd0);
        check("rst_wait_cnt", f_wait_cnt, 32'd0);
`endif
        RST = 1'b0;

        //   tag            freq faddr  ffl  lreq lwen laddr  lwdata        mrdy mrdata        hit done ren wen busy own  maddr  mwdata        rdata
        // Conflict from reset: fetch, loader write, fetch
        add("rr_idle0",     1, 'h44, 0,   1, 1, 'h100, 'h12345678,   0, 0,             0, 0, 0, 0, 0, 1,  0,     0,            0);
        add("rr_f_busy",    1, 'h44, 0,   1, 1, 'h100, 'h12345678,   1, 'h0A0A0A0A,    0, 0, 1, 0, 1, 0,  'h44,  0,            0);
        add("rr_f_hit",     1, 'h44, 0,   1, 1, 'h100, 'h12345678,   0, 0,             1, 0, 0, 0, 1, 0,  0,     0,            'h0A0A0A0A);
        add("rr_idle1",     1, 'h48, 0,   1, 1, 'h100, 'h12345678,   0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("rr_l_busy",    1, 'h48, 0,   1, 1, 'h100, 'h12345678,   1, 0,             0, 0, 0, 1, 1, 1,  'h100, 'h12345678,   0);
        add("rr_l_done",    1, 'h48, 0,   1, 1, 'h100, 'h12345678,   0, 0,             0, 1, 0, 0, 1, 1,  0,     0,            0);
        add("rr_idle2",     1, 'h48, 0,   0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 1,  0,     0,            0);
        add("rr_f2_busy",   1, 'h48, 0,   0, 0, 0,     0,            1, 'h11112222,    0, 0, 1, 0, 1, 0,  'h48,  0,            0);
        add("rr_f2_hit",    1, 'h48, 0,   0, 0, 0,     0,            0, 0,             1, 0, 0, 0, 1, 0,  0,     0,            'h11112222);
        add("rr_quiet",     0, 0,    0,   0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        // Fetch-only read
        add("fo_idle",      1, 'h40, 0,   0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("fo_busy",      1, 'h40, 0,   0, 0, 0,     0,            1, 'hDEADBEEF,    0, 0, 1, 0, 1, 0,  'h40,  0,            0);
        add("fo_hit",       1, 'h40, 0,   0, 0, 0,     0,            0, 0,             1, 0, 0, 0, 1, 0,  0,     0,            'hDEADBEEF);
        add("fo_after",     0, 0,    0,   0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        // Loader read, 5-cycle memory; a flush mid-access must not disturb it
        add("vl_idle",      0, 0,    0,   1, 0, 'h200, 0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("vl_busy1",     0, 0,    0,   1, 0, 'h200, 0,            0, 0,             0, 0, 1, 0, 1, 1,  'h200, 0,            0);
        add("vl_busy2",     0, 0,    0,   1, 0, 'h200, 0,            0, 0,             0, 0, 1, 0, 1, 1,  'h200, 0,            0);
        add("vl_busy3_fl",  0, 0,    1,   1, 0, 'h200, 0,            0, 0,             0, 0, 1, 0, 1, 1,  'h200, 0,            0);
        add("vl_busy4",     0, 0,    0,   1, 0, 'h200, 0,            0, 0,             0, 0, 1, 0, 1, 1,  'h200, 0,            0);
        add("vl_busy5",     0, 0,    0,   1, 0, 'h200, 0,            1, 'hCAFEF00D,    0, 0, 1, 0, 1, 1,  'h200, 0,            0);
        add("vl_done",      0, 0,    0,   1, 0, 'h200, 0,            0, 0,             0, 1, 0, 0, 1, 1,  0,     0,            'hCAFEF00D);
        add("vl_after",     0, 0,    0,   0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 1,  0,     0,            0);
        // Flush in second BUSY cycle, m_ready in fourth, then a clean refetch
        add("fd_idle",      1, 'h300, 0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 1,  0,     0,            0);
        add("fd_busy1",     1, 'h300, 0,  0, 0, 0,     0,            0, 0,             0, 0, 1, 0, 1, 0,  'h300, 0,            0);
        add("fd_busy2_fl",  0, 0,     1,  0, 0, 0,     0,            0, 0,             0, 0, 1, 0, 1, 0,  'h300, 0,            0);
        add("fd_busy3",     1, 'h400, 0,  0, 0, 0,     0,            0, 0,             0, 0, 1, 0, 1, 0,  'h300, 0,            0);
        add("fd_busy4",     1, 'h400, 0,  0, 0, 0,     0,            1, 'h55555555,    0, 0, 1, 0, 1, 0,  'h300, 0,            0);
        add("fd_resp",      1, 'h400, 0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 1, 0,  0,     0,            0);
        add("fd_idle2",     1, 'h400, 0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("fd_busy5",     1, 'h400, 0,  0, 0, 0,     0,            1, 'h66666666,    0, 0, 1, 0, 1, 0,  'h400, 0,            0);
        add("fd_hit",       1, 'h400, 0,  0, 0, 0,     0,            0, 0,             1, 0, 0, 0, 1, 0,  0,     0,            'h66666666);
        add("fd_quiet",     0, 0,     0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        // Flush with m_ready, then flush in IDLE blocking the grant
        add("fc_idle",      1, 'h500, 0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("fc_busy_fl",   1, 'h500, 1,  0, 0, 0,     0,            1, 'h77777777,    0, 0, 1, 0, 1, 0,  'h500, 0,            0);
        add("fc_resp",      0, 0,     0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 1, 0,  0,     0,            0);
        add("fc_idle_fl",   1, 'h600, 1,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("fc_idle_ok",   1, 'h600, 0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);
        add("fc_busy",      1, 'h600, 0,  0, 0, 0,     0,            1, 'h88888888,    0, 0, 1, 0, 1, 0,  'h600, 0,            0);
        add("fc_hit",       1, 'h600, 0,  0, 0, 0,     0,            0, 0,             1, 0, 0, 0, 1, 0,  0,     0,            'h88888888);
        add("fc_quiet",     0, 0,     0,  0, 0, 0,     0,            0, 0,             0, 0, 0, 0, 0, 0,  0,     0,            0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            check_vec(i, vq[i]);
            @(posedge CLK);
            #1;
        end

`ifdef IMEM_ARB_PERF_EN
        check("perf_drop_cnt", f_drop_cnt, 32'd2);
`endif

        // Reset asserted in the middle of a fetch access
        f_req = 1'b1; f_addr = 32'h700; f_flush = 1'b0;
        l_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
        @(posedge CLK);
        #1;
        check("mr_pre_ren", {31'd0, m_ren}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("mr_ren",   {31'd0, m_ren}, 32'd0);
        check("mr_owner", {31'd0, owner}, 32'd1);
        check("mr_busy",  {31'd0, busy},  32'd0);
`ifdef IMEM_ARB_PERF_EN
        check("mr_drop_cnt", f_drop_cnt, 32'd0);
`endif
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("mr_regrant_ren",  {31'd0, m_ren}, 32'd1);
        check("mr_regrant_addr", m_addr,          32'h700);
        check("mr_regrant_own",  {31'd0, owner}, 32'd0);
        m_ready = 1'b1; m_rdata = 32'h99999999;
        @(posedge CLK);
        #1;
        m_ready = 1'b0; m_rdata = '0;
        check("mr_hit",    {31'd0, f_hit}, 32'd1);
        check("mr_rdata",  f_rdata,         32'h99999999);
        f_req = 1'b0;
        @(posedge CLK);
        #1;
        check("mr_idle",   {31'd0, busy},  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
